zion_rr_arb_bin_idx: RTL and testbench

- Registered round-robin arbiter over N_REQ request lines.
- Emits the winner as a scaled binary index (START + STEP*winner) under a valid/ready handshake.
- Sits directly upstream of the binary-to-one-hot decoder: oIdx drives the decoder input, and the decoder must use the same START/STEP so its output bit equals the granted requester.

---
 rtl/zion_rr_arb_bin_idx.sv | 112 +++++++++++
 tb/tb_zion_rr_arb_bin_idx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zion_rr_arb_bin_idx.sv
// Registered round-robin arbiter. The winner is presented as a scaled binary index
// (START + STEP*winner) under a valid/ready handshake.
module zion_rr_arb_bin_idx #(
    parameter int unsigned N_REQ = 32,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned START = 0,
    parameter int unsigned STEP  = 1,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] iReq,
    input  logic             iRdy,
    output logic             oVld,
    output logic [OUT_W-1:0] oIdx,
    output logic [IDX_W-1:0] oSel,
    output logic [IDX_W-1:0] oPtr
);

    localparam longint unsigned MAX_IDX =
        longint'(START) + longint'(STEP) * longint'(N_REQ - 1);

    if ((MAX_IDX >> OUT_W) != 0) begin : g_bad_out_w
        $error("zion_rr_arb_bin_idx: OUT_W=%0d cannot hold index %0d", OUT_W, MAX_IDX);
    end
    if (STEP < 1 || N_REQ < 2 || N_REQ > 256) begin : g_bad_param
        $error("zion_rr_arb_bin_idx: illegal N_REQ=%0d / STEP=%0d", N_REQ, STEP);
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_sel;
    logic [OUT_W-1:0] r_idx;

    logic [IDX_W-1:0] w_next;
    logic [IDX_W-1:0] w_base;
    logic [IDX_W:0]   w_pos;
    logic [IDX_W-1:0] w_win;
    logic             w_any;
    logic [OUT_W-1:0] w_idx;

    // On accept the search starts at oSel+1, which is also the new pointer value.
    assign w_next = (r_sel == IDX_W'(N_REQ - 1)) ? '0 : r_sel + 1'b1;
    assign w_base = (r_state == GRANT) ? w_next : r_ptr;

    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_pos = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_pos = {1'b0, w_base} + (IDX_W + 1)'(i);
            if (w_pos >= (IDX_W + 1)'(N_REQ)) begin
                w_pos = w_pos - (IDX_W + 1)'(N_REQ);
            end
            if (!w_any && iReq[w_pos[IDX_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_pos[IDX_W-1:0];
            end
        end
    end

    assign w_idx = OUT_W'(START) + OUT_W'(STEP) * OUT_W'(w_win);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_idx   <= OUT_W'(START);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_win;
                        r_idx   <= w_idx;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (iRdy) begin
                        r_ptr <= w_next;
                        if (w_any) begin
                            r_sel <= w_win;
                            r_idx <= w_idx;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && r_state == IDLE) begin
            assert (!$isunknown(iReq))
            else $error("zion_rr_arb_bin_idx: X on iReq while idle");
        end
    end

    assign oVld = (r_state == GRANT);
    assign oIdx = r_idx;
    assign oSel = r_sel;
    assign oPtr = r_ptr;

endmodule

// File: tb/tb_zion_rr_arb_bin_idx.sv
// Bench for zion_rr_arb_bin_idx: a directed scenario list plus randomized traffic,
// checked every cycle against a transaction-level round-robin model.
module tb_zion_rr_arb_bin_idx;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;

    logic [31:0] req32 = '0;
    logic        rdy32 = 1'b0;
    logic        vld32;
    logic [31:0] idx32;
    logic [4:0]  sel32;
    logic [4:0]  ptr32;

    logic [7:0]  req8 = '0;
    logic        rdy8 = 1'b0;
    logic        vld8;
    logic [7:0]  idx8;
    logic [2:0]  sel8;
    logic [2:0]  ptr8;

    int errors = 0;
    int checks = 0;

    zion_rr_arb_bin_idx #(.N_REQ(32), .OUT_W(32), .START(0), .STEP(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .iReq(req32), .iRdy(rdy32),
        .oVld(vld32), .oIdx(idx32), .oSel(sel32), .oPtr(ptr32)
    );

    zion_rr_arb_bin_idx #(.N_REQ(8), .OUT_W(8), .START(4), .STEP(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .iReq(req8), .iRdy(rdy8),
        .oVld(vld8), .oIdx(idx8), .oSel(sel8), .oPtr(ptr8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: grant pending flag, granted requester, priority pointer.
    typedef struct packed {
        logic       vld;
        logic [7:0] sel;
        logic [7:0] ptr;
    } mstate_t;

    function automatic int pick(input logic [255:0] r, input int n, input int from);
        for (int k = 0; k < n; k++) begin
            if (r[(from + k) % n]) return (from + k) % n;
        end
        return -1;
    endfunction

    function automatic mstate_t mnext(input mstate_t s, input logic [255:0] r,
                                      input logic rdy, input int n);
        mstate_t nx;
        int w;
        nx = s;
        if (!s.vld) begin
            w = pick(r, n, int'(s.ptr));
            if (w >= 0) begin
                nx.vld = 1'b1;
                nx.sel = 8'(w);
            end
        end else if (rdy) begin
            nx.ptr = 8'((int'(s.sel) + 1) % n);
            w = pick(r, n, int'(nx.ptr));
            if (w >= 0) nx.sel = 8'(w);
            else        nx.vld = 1'b0;
        end
        return nx;
    endfunction

    mstate_t m32 = '0;
    mstate_t m8  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m32 <= '0;
            m8  <= '0;
        end else begin
            m32 <= mnext(m32, 256'(req32), rdy32, 32);
            m8  <= mnext(m8, 256'(req8), rdy8, 8);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_vld32", 64'(vld32), 64'(m32.vld));
            chk("model_sel32", 64'(sel32), 64'(m32.sel));
            chk("model_ptr32", 64'(ptr32), 64'(m32.ptr));
            chk("model_idx32", 64'(idx32), 64'(m32.sel));
            chk("model_vld8",  64'(vld8),  64'(m8.vld));
            chk("model_sel8",  64'(sel8),  64'(m8.sel));
            chk("model_ptr8",  64'(ptr8),  64'(m8.ptr));
            chk("model_idx8",  64'(idx8),  64'(4 + 3 * int'(m8.sel)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int cnt [32];
    logic [31:0] dec;

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        step();
        step();
        chk("rst_vld", 64'(vld32), 64'd0);
        chk("rst_sel", 64'(sel32), 64'd0);
        chk("rst_idx", 64'(idx32), 64'd0);
        chk("rst_ptr", 64'(ptr32), 64'd0);
        chk("rst_idx8_start", 64'(idx8), 64'd4);
        rst_n = 1'b1;

        // Idle: no requests, nothing happens.
        repeat (5) step();
        chk("idle_vld", 64'(vld32), 64'd0);
        chk("idle_ptr", 64'(ptr32), 64'd0);

        // Backpressure and sticky grant.
        req32 = 32'h5;
        rdy32 = 1'b0;
        step();
        for (int c = 1; c <= 4; c++) begin
            chk("bp_vld", 64'(vld32), 64'd1);
            chk("bp_sel", 64'(sel32), 64'd0);
            chk("bp_ptr", 64'(ptr32), 64'd0);
            if (c == 2) req32 = 32'h4;
            if (c < 4) step();
        end
        rdy32 = 1'b1;
        step();
        chk("bp_next_sel", 64'(sel32), 64'd2);
        chk("bp_next_ptr", 64'(ptr32), 64'd1);
        req32 = '0;
        step();
        chk("bp_drain_vld", 64'(vld32), 64'd0);
        chk("bp_drain_ptr", 64'(ptr32), 64'd3);

        // Accept of oSel=3 coincident with iReq=9: search starts at 4, wraps to 0.
        req32 = 32'h8;
        rdy32 = 1'b0;
        step();
        chk("sim_sel3", 64'(sel32), 64'd3);
        req32 = 32'h9;
        rdy32 = 1'b1;
        step();
        chk("sim_sel0", 64'(sel32), 64'd0);
        chk("sim_ptr4", 64'(ptr32), 64'd4);
        req32 = '0;
        step();
        chk("sim_ptr1", 64'(ptr32), 64'd1);

        // Single requester and downstream decoder.
        req32 = 32'h0000_0100;
        rdy32 = 1'b1;
        step();
        chk("single_vld", 64'(vld32), 64'd1);
        chk("single_sel", 64'(sel32), 64'd8);
        chk("single_idx", 64'(idx32), 64'd8);
        dec = 32'h1 << ((idx32 - 32'd0) / 32'd1);
        chk("single_decoder", 64'(dec), 64'h100);
        req32 = '0;
        step();
        chk("single_ptr9", 64'(ptr32), 64'd9);
        chk("single_vld0", 64'(vld32), 64'd0);

        // Asynchronous reset in the middle of a stalled grant.
        req32 = 32'h1;
        rdy32 = 1'b0;
        step();
        chk("mid_pre_vld", 64'(vld32), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 64'(vld32), 64'd0);
        chk("mid_rst_idx", 64'(idx32), 64'd0);
        chk("mid_rst_ptr", 64'(ptr32), 64'd0);
        chk("mid_rst_idx8", 64'(idx8), 64'd4);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_post_vld", 64'(vld32), 64'd1);
        chk("mid_post_sel", 64'(sel32), 64'd0);
        rdy32 = 1'b1;
        req32 = '0;
        step();

        // Round robin with wrap, all requests high from reset.
        rst_n = 1'b0;
        req32 = 32'hFFFF_FFFF;
        rdy32 = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) cnt[i] = 0;
        for (int k = 0; k < 34; k++) begin
            step();
            chk("rr_vld", 64'(vld32), 64'd1);
            chk("rr_sel", 64'(sel32), 64'(k % 32));
            chk("rr_ptr", 64'(ptr32), 64'(k % 32));
            if (k < 32) cnt[sel32]++;
        end
        for (int i = 0; i < 32; i++) chk("rr_fair", 64'(cnt[i]), 64'd1);
        req32 = '0;
        step();

        // Scaled index on the N_REQ=8, START=4, STEP=3 instance.
        req8 = 8'h80;
        rdy8 = 1'b0;
        step();
        chk("scaled_sel", 64'(sel8), 64'd7);
        chk("scaled_idx", 64'(idx8), 64'd25);
        req8 = '0;
        rdy8 = 1'b1;
        step();
        chk("scaled_ptr_wrap", 64'(ptr8), 64'd0);

        // Randomized traffic on both instances.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom % 4)
                0: req32 = '0;
                1: req32 = 32'h1 << ($urandom % 32);
                2: req32 = $urandom;
                default: req32 = $urandom & $urandom & $urandom;
            endcase
            case ($urandom % 3)
                0: req8 = '0;
                1: req8 = 8'h1 << ($urandom % 8);
                default: req8 = 8'($urandom);
            endcase
            rdy32 = ($urandom % 3) != 0;
            rdy8  = ($urandom % 4) == 0;
            step();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
